// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Turns the host byte stream into register writes and reads for the camera
// and filter control registers. Each completed packet yields exactly one
// response byte pushed into the UART TX FIFO.
//
//   Write packet : 'W' (0x57), addr, data   -> response 'K' or 'E'
//   Read packet  : 'R' (0x52), addr         -> response read data or 'E'
//   Unknown command byte                    -> response 'E'
//
// Optional build macro UART_CMD_CHECKSUM_EN: when defined, every packet
// carries one trailing byte equal to the XOR of all preceding packet bytes.
// A mismatch answers 'C' (0x43) and performs neither the write nor the read.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   i_rx_valid     one-cycle strobe, i_rx_data holds a received byte
//   i_rx_data      received byte
//   i_tx_full      TX FIFO full; no push is issued while high
//   o_tx_push      one-cycle push of o_tx_data into the TX FIFO
//   o_tx_data      response byte
//   o_reg_wr_en    one-cycle register write strobe
//   o_reg_addr     register address, stable from capture until next packet
//   o_reg_wr_data  register write data
//   i_reg_rd_data  combinational read data for o_reg_addr
//   o_busy         high whenever the parser is not idle
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
   parameter int NUM_REGS       = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx_valid,
   input  logic [7:0] i_rx_data,
   input  logic       i_tx_full,
   output logic       o_tx_push,
   output logic [7:0] o_tx_data,
   output logic       o_reg_wr_en,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wr_data,
   input  logic [7:0] i_reg_rd_data,
   output logic       o_busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
   localparam logic [7:0] RESP_OK   = 8'h4B;  // 'K'
   localparam logic [7:0] RESP_ERR  = 8'h45;  // 'E'
`ifdef UART_CMD_CHECKSUM_EN
   localparam logic [7:0] RESP_CSUM = 8'h43;  // 'C'
`endif

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
      GET_CSUM,
`endif
      EXEC,
      RESP
   } state_t;

   state_t           state_reg;
   logic             is_write_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [7:0]       resp_reg;
   logic             wr_en_reg;
   logic [7:0]       addr_reg;
   logic [7:0]       wr_data_reg;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]       csum_reg;
   logic             csum_ok_reg;
`endif

   logic waiting;
   logic timeout_hit;

   function automatic logic addr_in_range(input logic [7:0] a);
      return (32'(a) < 32'(NUM_REGS));
   endfunction

   // States that wait for the next byte of a packet and are subject to the
   // inter-byte timeout.
   always_comb begin
      waiting = (state_reg == GET_ADDR) || (state_reg == GET_DATA);
`ifdef UART_CMD_CHECKSUM_EN
      if (state_reg == GET_CSUM) begin
         waiting = 1'b1;
      end
`endif
   end

   // An arriving byte always beats an expiring timeout in the same cycle.
   assign timeout_hit = waiting && !i_rx_valid && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         is_write_reg <= 1'b0;
         cnt_reg      <= '0;
         resp_reg     <= 8'h00;
         wr_en_reg    <= 1'b0;
         addr_reg     <= 8'h00;
         wr_data_reg  <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
         csum_reg     <= 8'h00;
         csum_ok_reg  <= 1'b0;
`endif
      end else begin
         wr_en_reg <= 1'b0;

         // Inter-byte counter: runs only while waiting with no byte, and
         // clears on a byte, on expiry, and in every other state.
         if (waiting && !i_rx_valid && !timeout_hit) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end else begin
            cnt_reg <= '0;
         end

         case (state_reg)
            IDLE: begin
               if (i_rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                  csum_reg <= i_rx_data;
`endif
                  if (i_rx_data == CMD_WRITE) begin
                     is_write_reg <= 1'b1;
                     state_reg    <= GET_ADDR;
                  end else if (i_rx_data == CMD_READ) begin
                     is_write_reg <= 1'b0;
                     state_reg    <= GET_ADDR;
                  end else begin
                     resp_reg  <= RESP_ERR;
                     state_reg <= RESP;
                  end
               end
            end

            GET_ADDR: begin
               if (i_rx_valid) begin
                  addr_reg <= i_rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                  csum_reg <= csum_reg ^ i_rx_data;
`endif
                  if (is_write_reg) begin
                     state_reg <= GET_DATA;
                  end else begin
`ifdef UART_CMD_CHECKSUM_EN
                     state_reg <= GET_CSUM;
`else
                     state_reg <= EXEC;
`endif
                  end
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end
            end

            GET_DATA: begin
               if (i_rx_valid) begin
                  wr_data_reg <= i_rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                  csum_reg  <= csum_reg ^ i_rx_data;
                  state_reg <= GET_CSUM;
`else
                  // The strobe is registered so that it is high exactly
                  // during the EXEC cycle.
                  wr_en_reg <= addr_in_range(addr_reg);
                  state_reg <= EXEC;
`endif
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end
            end

`ifdef UART_CMD_CHECKSUM_EN
            GET_CSUM: begin
               if (i_rx_valid) begin
                  csum_ok_reg <= (i_rx_data == csum_reg);
                  wr_en_reg   <= is_write_reg && addr_in_range(addr_reg) &&
                                 (i_rx_data == csum_reg);
                  state_reg   <= EXEC;
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end
            end
`endif

            EXEC: begin
               // The address is stable here, so the combinational read data
               // belongs to this packet.
`ifdef UART_CMD_CHECKSUM_EN
               if (!csum_ok_reg) begin
                  resp_reg <= RESP_CSUM;
               end else
`endif
               if (!addr_in_range(addr_reg)) begin
                  resp_reg <= RESP_ERR;
               end else if (is_write_reg) begin
                  resp_reg <= RESP_OK;
               end else begin
                  resp_reg <= i_reg_rd_data;
               end
               state_reg <= RESP;
            end

            RESP: begin
               if (!i_tx_full) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Push is gated by i_tx_full in the same cycle so a full FIFO is never
   // pushed, while still allowing a push in the first RESP cycle.
   assign o_tx_push     = (state_reg == RESP) && !i_tx_full;
   assign o_tx_data     = resp_reg;
   assign o_reg_wr_en   = wr_en_reg;
   assign o_reg_addr    = addr_reg;
   assign o_reg_wr_data = wr_data_reg;
   assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

   logic       clk;
   logic       reset;
   logic       i_rx_valid;
   logic [7:0] i_rx_data;
   logic       i_tx_full;
   logic       o_tx_push;
   logic [7:0] o_tx_data;
   logic       o_reg_wr_en;
   logic [7:0] o_reg_addr;
   logic [7:0] o_reg_wr_data;
   logic [7:0] i_reg_rd_data;
   logic       o_busy;

   uart_cmd_parser #(
      .NUM_REGS      (16),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_rx_valid   (i_rx_valid),
      .i_rx_data    (i_rx_data),
      .i_tx_full    (i_tx_full),
      .o_tx_push    (o_tx_push),
      .o_tx_data    (o_tx_data),
      .o_reg_wr_en  (o_reg_wr_en),
      .o_reg_addr   (o_reg_addr),
      .o_reg_wr_data(o_reg_wr_data),
      .i_reg_rd_data(i_reg_rd_data),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      int         at;   // expected cycle, -1 = any
   } tx_exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         at;
   } wr_exp_t;

   typedef struct {
      string       nm;
      int          sel;  // 0: o_busy, 1: all outputs packed
      logic [31:0] exp;
      int          at;
   } probe_t;

   tx_exp_t tx_q[$];
   wr_exp_t wr_q[$];
   probe_t  pr_q[$];

   int  n_cmp = 0;
   int  n_err = 0;
   int  t_last = 0;
   bit  done = 1'b0;

   tx_exp_t     tx_e;
   wr_exp_t     wr_e;
   probe_t      pr_e;
   logic [31:0] act;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (o_tx_push) begin
         n_cmp++;
         if (i_tx_full) begin
            n_err++;
            $display("FAIL push_while_full: push=1 with tx_full=1 at cycle %0d, required no push", cyc);
         end
         if (tx_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_push: got 0x%02h at cycle %0d, required no push", o_tx_data, cyc);
         end else begin
            tx_e = tx_q.pop_front();
            if (o_tx_data !== tx_e.d || (tx_e.at >= 0 && cyc != tx_e.at)) begin
               n_err++;
               $display("FAIL tx_push: got 0x%02h at cycle %0d, required 0x%02h at cycle %0d", o_tx_data, cyc, tx_e.d, tx_e.at);
            end else begin
               $display("push 0x%02h at cycle %0d ok", o_tx_data, cyc);
            end
         end
      end
      if (o_reg_wr_en) begin
         n_cmp++;
         if (wr_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%02h data 0x%02h at cycle %0d, required no write", o_reg_addr, o_reg_wr_data, cyc);
         end else begin
            wr_e = wr_q.pop_front();
            if (o_reg_addr !== wr_e.a || o_reg_wr_data !== wr_e.d || cyc != wr_e.at) begin
               n_err++;
               $display("FAIL reg_write: got addr 0x%02h data 0x%02h cycle %0d, required addr 0x%02h data 0x%02h cycle %0d",
                        o_reg_addr, o_reg_wr_data, cyc, wr_e.a, wr_e.d, wr_e.at);
            end else begin
               $display("write addr 0x%02h data 0x%02h at cycle %0d ok", o_reg_addr, o_reg_wr_data, cyc);
            end
         end
      end
      while (pr_q.size() > 0 && pr_q[0].at <= cyc) begin
         pr_e = pr_q.pop_front();
         if (pr_e.sel == 0) act = {31'd0, o_busy};
         else act = {6'd0, o_tx_push, o_tx_data, o_reg_wr_en, o_reg_addr, o_reg_wr_data, o_busy};
         n_cmp++;
         if (act !== pr_e.exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", pr_e.nm, act, pr_e.exp, cyc);
         end else begin
            $display("check %s = 0x%0h at cycle %0d ok", pr_e.nm, act, cyc);
         end
      end
      if (done) begin
         n_cmp++;
         if (tx_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_push: %0d responses never pushed, required 0", tx_q.size());
         end
         n_cmp++;
         if (wr_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_write: %0d writes never seen, required 0", wr_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers are entered and left 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(posedge clk);
      #1;
      i_rx_valid = 1'b0;
      t_last     = cyc;
   endtask

   task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] a,
                           input logic [7:0] d, input bit has_data);
      logic [7:0] cs;
      cs = cmd ^ a;
      send_byte(cmd);
      send_byte(a);
      if (has_data) begin
         send_byte(d);
         cs = cs ^ d;
      end
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(cs);
`endif
   endtask

   task automatic exp_tx(input logic [7:0] d, input int at);
      tx_q.push_back('{d: d, at: at});
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input int at);
      wr_q.push_back('{a: a, d: d, at: at});
   endtask

   task automatic probe(input string nm, input int sel, input logic [31:0] exp);
      pr_q.push_back('{nm: nm, sel: sel, exp: exp, at: cyc});
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (o_busy && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (o_busy) probe("wait_idle_bound", 0, 32'd0);
      idle(2);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset         = 1'b1;
      i_rx_valid    = 1'b0;
      i_rx_data     = 8'h00;
      i_tx_full     = 1'b0;
      i_reg_rd_data = 8'h00;
      idle(3);
      reset = 1'b0;
      probe("reset_state", 1, 32'd0);
      idle(2);

      // Write 0x03 <- 0xA5: strobe in EXEC, 'K' on the next cycle.
      send_pkt(8'h57, 8'h03, 8'hA5, 1'b1);
      exp_wr(8'h03, 8'hA5, t_last);
      exp_tx(8'h4B, t_last + 1);
      wait_idle(20);

      // Read 0x07 with read data 0x3C.
      i_reg_rd_data = 8'h3C;
      send_pkt(8'h52, 8'h07, 8'h00, 1'b0);
      exp_tx(8'h3C, t_last + 1);
      wait_idle(20);

      // Unknown command byte answers 'E' straight away.
      send_byte(8'h41);
      exp_tx(8'h45, t_last);
      wait_idle(20);

      // Address 0x10 is out of range for 16 registers: 'E', no write.
      send_pkt(8'h57, 8'h10, 8'h01, 1'b1);
      exp_tx(8'h45, t_last + 1);
      wait_idle(20);

      // Highest valid address (boundary).
      send_pkt(8'h57, 8'h0F, 8'hC3, 1'b1);
      exp_wr(8'h0F, 8'hC3, t_last);
      exp_tx(8'h4B, t_last + 1);
      wait_idle(20);

      // Backpressure: response held for 50 cycles, a stray byte is dropped.
      i_tx_full = 1'b1;
      send_pkt(8'h57, 8'h05, 8'h5A, 1'b1);
      exp_wr(8'h05, 8'h5A, t_last);
      idle(1);
      for (int i = 0; i < 50; i++) begin
         probe("busy_while_full", 0, 32'd1);
         if (i == 10) send_byte(8'h41);
         else idle(1);
      end
      i_tx_full = 1'b0;
      exp_tx(8'h4B, cyc);
      idle(1);
      probe("idle_after_push", 0, 32'd0);
      idle(2);

      // Timeout: expiry exactly 100 cycles after the last accepted byte.
      send_byte(8'h57);
      send_byte(8'h02);
      idle(99);
      probe("timeout_not_yet", 0, 32'd1);
      idle(1);
      probe("timeout_expired", 0, 32'd0);
      idle(3);
      i_reg_rd_data = 8'h99;
      send_pkt(8'h52, 8'h02, 8'h00, 1'b0);
      exp_tx(8'h99, t_last + 1);
      wait_idle(20);

      // Reset mid-packet: packet discarded, all outputs cleared.
      send_byte(8'h57);
      reset = 1'b1;
      idle(1);
      probe("reset_mid_packet", 1, 32'd0);
      reset = 1'b0;
      idle(20);

      // Reset while a response waits on a full FIFO: response discarded.
      i_tx_full = 1'b1;
      send_pkt(8'h57, 8'h06, 8'h77, 1'b1);
      exp_wr(8'h06, 8'h77, t_last);
      idle(3);
      reset = 1'b1;
      idle(1);
      probe("reset_mid_resp", 1, 32'd0);
      reset = 1'b0;
      i_tx_full = 1'b0;
      idle(10);

`ifdef UART_CMD_CHECKSUM_EN
      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h46);
      exp_wr(8'h01, 8'h10, t_last);
      exp_tx(8'h4B, t_last + 1);
      wait_idle(20);

      send_byte(8'h57);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h47);
      exp_tx(8'h43, t_last + 1);
      wait_idle(20);
`endif

      idle(5);
      done = 1'b1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not reach the summary in time");
      $fatal(1);
   end

endmodule
